bcd_convert_scheduler: RTL and testbench

Shares one iterative shift-and-add-3 (double-dabble) binary-to-BCD engine between two requesters in the lab2 display path. Each requester presents a 7-bit binary value (0–127). The block arbitrates round-robin, sequences the 7-step conversion, and returns three BCD digits tagged with the requester ID. It sits between the value sources (counter/switch logic) and the seven-segment digit driver.

---
 rtl/bcd_convert_scheduler.sv | 85 ++++++++
 tb/tb_bcd_convert_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: round-robin shared double-dabble binary-to-BCD converter
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req0/1    - level conversion requests
//   num0/1    - 7-bit binary values, sampled on the grant edge
//   grant0/1  - one-cycle pulse, corresponding num was captured
//   busy      - high while a conversion is in progress
//   done      - one-cycle pulse, result outputs updated
//   doneId    - requester that owns the current result
//   hundreds/tens/ones - BCD result digits, held until the next done
module bcd_convert_scheduler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [6:0] num0,
    input  logic       req1,
    input  logic [6:0] num1,
    output logic       grant0,
    output logic       grant1,
    output logic       busy,
    output logic       done,
    output logic       doneId,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t      state, state_n;
    logic [18:0] sr, sr_adj, sr_shift;
    logic [2:0]  step;
    logic        owner, last_grant, pick1, start, last;
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction
    always_comb begin
        sr_adj   = {add3(sr[18:15]), add3(sr[14:11]), add3(sr[10:7]), sr[6:0]};
        sr_shift = sr_adj << 1;
        // On a tie the requester that did not win last time takes the engine.
        pick1    = req1 & (~req0 | ~last_grant);
        start    = (state == IDLE) & (req0 | req1);
        last     = (state == SHIFT) & (step == 3'd6);
        state_n  = start ? SHIFT : last ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            step       <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            done       <= 1'b0;
            doneId     <= 1'b0;
            hundreds   <= '0;
            tens       <= '0;
            ones       <= '0;
        end else begin
            grant0 <= start & ~pick1;
            grant1 <= start & pick1;
            done   <= last;
            if (start) begin
                sr         <= {12'b0, pick1 ? num1 : num0};
                step       <= '0;
                owner      <= pick1;
                last_grant <= pick1;
            end else if (state == SHIFT) begin
                sr   <= sr_shift;
                step <= step + 3'd1;
            end
            if (last) begin
                hundreds <= sr_shift[18:15];
                tens     <= sr_shift[14:11];
                ones     <= sr_shift[10:7];
                doneId   <= owner;
            end
        end
    end
    assign busy = (state == SHIFT);
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb_bcd_convert_scheduler: directed table-driven bench for bcd_convert_scheduler
module tb_bcd_convert_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [6:0] num0 = '0, num1 = '0;
    logic       grant0, grant1, busy, done, doneId;
    logic [3:0] hundreds, tens, ones;
    int total = 0, bad = 0;

    bcd_convert_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .num0(num0), .req1(req1), .num1(num1),
        .grant0(grant0), .grant1(grant1), .busy(busy), .done(done),
        .doneId(doneId), .hundreds(hundreds), .tens(tens), .ones(ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [6:0] num;
        int         h, t, o;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int n, output logic g0, output logic g1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 10 && !grant0 && !grant1);
        g0 = grant0;
        g1 = grant1;
    endtask

    task automatic wait_done(output int n, output logic odd);
        n = 0;
        odd = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!done && !busy) odd = 1'b1;
            if (grant0 || grant1) odd = 1'b1;
        end while (n < 12 && !done);
    endtask

    task automatic check_result(input string tag, input int id, input int h, input int t, input int o);
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " busy_at_done"}, int'(busy), 0);
        chk({tag, " id"}, int'(doneId), id);
        chk({tag, " digits"}, int'(hundreds) * 100 + int'(tens) * 10 + int'(ones), h * 100 + t * 10 + o);
        chk({tag, " hundreds"}, int'(hundreds), h);
    endtask

    initial begin
        int n, m;
        logic g0, g1, odd, prev_busy;
        int grants, dones, last_done;
        int gseq[4];
        vecs[0] = '{1'b0, 7'd127, 1, 2, 7};
        vecs[1] = '{1'b1, 7'd0,   0, 0, 0};
        vecs[2] = '{1'b1, 7'd9,   0, 0, 9};
        vecs[3] = '{1'b1, 7'd10,  0, 1, 0};
        vecs[4] = '{1'b1, 7'd99,  0, 9, 9};
        vecs[5] = '{1'b1, 7'd100, 1, 0, 0};
        vecs[6] = '{1'b1, 7'd127, 1, 2, 7};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle outputs", {grant0, grant1, busy, done, doneId, hundreds, tens, ones}, 0);
        end

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].sel) begin req1 = 1'b1; num1 = vecs[i].num; end
            else begin req0 = 1'b1; num0 = vecs[i].num; end
            wait_grant(n, g0, g1);
            chk($sformatf("v%0d grant_lat", i), n, 1);
            chk($sformatf("v%0d grant_id", i), {g1, g0}, vecs[i].sel ? 2 : 1);
            chk($sformatf("v%0d busy_at_grant", i), int'(busy), 1);
            req0 = 1'b0;
            req1 = 1'b0;
            wait_done(n, odd);
            chk($sformatf("v%0d done_lat", i), n, 7);
            chk($sformatf("v%0d busy_grant_ok", i), int'(odd), 0);
            check_result($sformatf("v%0d", i), int'(vecs[i].sel), vecs[i].h, vecs[i].t, vecs[i].o);
            @(negedge clk);
            chk($sformatf("v%0d done_pulse", i), int'(done), 0);
            chk($sformatf("v%0d hold", i), int'(hundreds) * 100 + int'(tens) * 10 + int'(ones),
                vecs[i].h * 100 + vecs[i].t * 10 + vecs[i].o);
        end

        req0 = 1'b1; num0 = 7'd42;
        req1 = 1'b1; num1 = 7'd85;
        grants = 0; dones = 0; last_done = 0; prev_busy = 1'b0;
        for (int c = 1; c <= 50 && dones < 4; c++) begin
            @(negedge clk);
            if (grant0 && grant1) chk("rr both grants", 1, 0);
            if ((grant0 || grant1) && done) chk("rr grant_with_done", 1, 0);
            if (grant0 || grant1) begin
                chk("rr busy_before_grant", int'(prev_busy), 0);
                if (grants < 4) gseq[grants] = grant1 ? 1 : 0;
                grants++;
            end
            if (done) begin
                if (dones > 0) chk("rr done_spacing", c - last_done, 8);
                last_done = c;
                if (dones % 2 == 0) check_result("rr id0", 0, 0, 4, 2);
                else                check_result("rr id1", 1, 0, 8, 5);
                dones++;
                if (dones == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
            prev_busy = busy;
        end
        chk("rr done_count", dones, 4);
        chk("rr grant_count", grants, 4);
        for (int i = 0; i < 4 && i < grants; i++) chk($sformatf("rr order%0d", i), gseq[i], i % 2);
        repeat (3) @(negedge clk);
        chk("rr quiet", {grant0, grant1, busy, done}, 0);

        req0 = 1'b1; num0 = 7'd50;
        wait_grant(n, g0, g1);
        chk("late grant0", int'(g0), 1);
        req0 = 1'b0;
        @(negedge clk);
        num0 = 7'd3;
        wait_done(m, odd);
        chk("late done_lat", m, 6);
        check_result("late", 0, 0, 5, 0);

        repeat (2) @(negedge clk);
        req0 = 1'b1; num0 = 7'd99;
        wait_grant(n, g0, g1);
        chk("abort grant0", int'(g0), 1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort async outputs", {grant0, grant1, busy, done, doneId, hundreds, tens, ones}, 0);
        odd = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) odd = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy || grant0 || grant1) odd = 1'b1;
        end
        chk("abort no_done", int'(odd), 0);
        chk("abort reset_outputs", {doneId, hundreds, tens, ones}, 0);

        req1 = 1'b1; num1 = 7'd64;
        wait_grant(n, g0, g1);
        chk("post grant1", int'(g1), 1);
        req1 = 1'b0;
        wait_done(n, odd);
        chk("post done_lat", n, 7);
        check_result("post", 1, 0, 6, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
